lfsr_demux_sequencer: RTL and testbench

LFSR_DEMUX_SEQUENCER -- requirements
Module: lfsr_demux_sequencer

---
 rtl/lfsr_demux_pkg.sv | 43 ++++
 rtl/lfsr_gen.sv | 35 +++
 rtl/lfsr_demux_sequencer.sv | 121 ++++++++++++
 tb/tb_lfsr_demux_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_demux_pkg.sv
// Shared definitions for the LFSR demux sequencer: mode encoding and the
// maximal-length Fibonacci tap masks for LFSR widths 3..24.
package lfsr_demux_pkg;

  typedef enum logic [1:0] {
    MODE_SELECT = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_ALL    = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  // Tap mask: bit (n-1) set for polynomial term x^n. Widths outside 3..24 return 0.
  function automatic logic [23:0] lfsr_taps(input int unsigned width);
    logic [23:0] m;
    case (width)
      3:       m = 24'h000006;
      4:       m = 24'h00000C;
      5:       m = 24'h000014;
      6:       m = 24'h000030;
      7:       m = 24'h000060;
      8:       m = 24'h0000B8;
      9:       m = 24'h000110;
      10:      m = 24'h000240;
      11:      m = 24'h000500;
      12:      m = 24'h000829;
      13:      m = 24'h00100D;
      14:      m = 24'h002015;
      15:      m = 24'h006000;
      16:      m = 24'h00D008;
      17:      m = 24'h012000;
      18:      m = 24'h020400;
      19:      m = 24'h040023;
      20:      m = 24'h090000;
      21:      m = 24'h140000;
      22:      m = 24'h300000;
      23:      m = 24'h420000;
      24:      m = 24'hE10000;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Fibonacci LFSR with enable. o_period_end flags the cycle whose
// advance brings the register back to SEED.
module lfsr_gen
  import lfsr_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned SEED  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_lfsr_data,
  output logic             o_period_end
);

  localparam logic [23:0]      TAP_ALL  = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAP_ALL[WIDTH-1:0];
  localparam logic [23:0]      SEED_ALL = 24'(SEED);
  localparam logic [WIDTH-1:0] SEED_V   = SEED_ALL[WIDTH-1:0];

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  // Shift toward the MSB, XOR of tapped bits enters at bit 0.
  always_comb lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

  // LFSR register: reset/reload to SEED, advance only when enabled.
  always_ff @(posedge i_clk) begin
    if (i_rst)     lfsr_q <= SEED_V;
    else if (i_en) lfsr_q <= lfsr_d;
  end

  assign o_lfsr_data  = lfsr_q;
  assign o_period_end = i_en && (lfsr_d == SEED_V);

endmodule

// File: rtl/lfsr_demux_sequencer.sv
// LFSR-timed demux sequencer: a toggle bit and scan index advance once per LFSR
// period and are steered onto NUM_CH registered outputs according to i_mode.
// Optional macro LFSR_DEMUX_SEQUENCER_SYNC_EN: two-flop synchronizers on
// i_sel, i_mode and i_hold (adds two cycles of input-to-effect latency).
module lfsr_demux_sequencer
  import lfsr_demux_pkg::*;
#(
  parameter  int unsigned LFSR_WIDTH = 22,
  parameter  int unsigned LFSR_SEED  = 1,
  parameter  int unsigned NUM_CH     = 4,
  localparam int unsigned SEL_W      = $clog2(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [1:0]        i_mode,
  input  logic              i_hold,
  output logic [NUM_CH-1:0] o_data,
  output logic              o_tick
);

  if (LFSR_WIDTH < 3 || LFSR_WIDTH > 24) begin : g_bad_width
    $error("lfsr_demux_sequencer: LFSR_WIDTH must be 3..24");
  end
  if (LFSR_SEED == 0 || LFSR_SEED >= (1 << LFSR_WIDTH)) begin : g_bad_seed
    $error("lfsr_demux_sequencer: LFSR_SEED must be nonzero and below 2^LFSR_WIDTH");
  end
  if (NUM_CH < 2 || NUM_CH > 16 || (NUM_CH & (NUM_CH - 1)) != 0) begin : g_bad_ch
    $error("lfsr_demux_sequencer: NUM_CH must be a power of two in 2..16");
  end

  logic [SEL_W-1:0] sel_u;
  logic [1:0]       mode_raw;
  logic             hold_u;
  mode_e            mode_u;

`ifdef LFSR_DEMUX_SEQUENCER_SYNC_EN
  logic [SEL_W+2:0] sync1_q, sync2_q;

  // Two-flop synchronizer for the control inputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {i_hold, i_mode, i_sel};
      sync2_q <= sync1_q;
    end
  end

  assign {hold_u, mode_raw, sel_u} = sync2_q;
`else
  assign hold_u   = i_hold;
  assign mode_raw = i_mode;
  assign sel_u    = i_sel;
`endif

  assign mode_u = mode_e'(mode_raw);

  logic [LFSR_WIDTH-1:0] lfsr_w;
  logic                  period_end;

  lfsr_gen #(
    .WIDTH (LFSR_WIDTH),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (!hold_u),
    .o_lfsr_data  (lfsr_w),
    .o_period_end (period_end)
  );

  // The all-zero state is the lock-up state of an XOR LFSR and must never appear.
  always_ff @(posedge i_clk) begin
    if (!i_rst) assert (lfsr_w != '0);
  end

  logic              tog_q;
  logic [SEL_W-1:0]  idx_q;
  logic              pe_q;
  logic              tick_q;
  logic [NUM_CH-1:0] data_q, data_d;

  // Output pattern from the current toggle/index state and the selected mode.
  always_comb begin
    data_d = '0;
    case (mode_u)
      MODE_SELECT: data_d[sel_u] = tog_q;
      MODE_SCAN:   data_d[idx_q] = 1'b1;
      MODE_ALL:    data_d        = {NUM_CH{tog_q}};
      default:     data_d        = '0;
    endcase
  end

  // Period-driven state and registered outputs. pe_q delays the period-end
  // flag so o_tick lines up with the o_data update that follows a toggle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tog_q  <= 1'b0;
      idx_q  <= '0;
      pe_q   <= 1'b0;
      data_q <= '0;
      tick_q <= 1'b0;
    end else if (hold_u) begin
      tick_q <= 1'b0;
    end else begin
      data_q <= data_d;
      tick_q <= pe_q;
      pe_q   <= period_end;
      if (period_end) begin
        tog_q <= ~tog_q;
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign o_data = data_q;
  assign o_tick = tick_q;

endmodule

// File: tb/tb_lfsr_demux_sequencer.sv
// Directed + randomized bench for lfsr_demux_sequencer (LFSR_WIDTH=3, NUM_CH=4).
module tb_lfsr_demux_sequencer;

  localparam int P = 7;

  logic       clk;
  logic       rst;
  logic [1:0] sel;
  logic [1:0] mode;
  logic       hold;
  logic [3:0] data;
  logic       tick;

  lfsr_demux_sequencer #(
    .LFSR_WIDTH (3),
    .LFSR_SEED  (1),
    .NUM_CH     (4)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_sel  (sel),
    .i_mode (mode),
    .i_hold (hold),
    .o_data (data),
    .o_tick (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic       t;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   edge_n = 0;

  // Reference state: a cycle counter stands in for the LFSR sequence.
  int         m_cnt = 0;
  logic       m_tog = 1'b0;
  logic [1:0] m_idx = '0;
  logic       m_pe = 1'b0;
  logic       m_tick = 1'b0;
  logic [3:0] m_data = '0;
  logic [1:0] sm1 = '0, sm2 = '0, ss1 = '0, ss2 = '0;
  logic       sh1 = 1'b0, sh2 = 1'b0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b edge=%0d", tag, obs, exp, edge_n);
    end
  endtask

  function automatic logic [3:0] exp_data(input logic [1:0] md, input logic [1:0] s,
                                          input logic tg, input logic [1:0] ix);
    logic [3:0] d;
    d = '0;
    case (md)
      2'b00:   d[s]  = tg;
      2'b01:   d[ix] = 1'b1;
      2'b10:   d     = {4{tg}};
      default: d     = '0;
    endcase
    return d;
  endfunction

  // One clock: predict, push, advance, pop and compare.
  task automatic cyc();
    logic [1:0] um, us;
    logic       uh;
    exp_t       e;
`ifdef LFSR_DEMUX_SEQUENCER_SYNC_EN
    um = sm2; us = ss2; uh = sh2;
    if (rst) begin
      sm1 = '0; sm2 = '0; ss1 = '0; ss2 = '0; sh1 = 1'b0; sh2 = 1'b0;
    end else begin
      sm2 = sm1; ss2 = ss1; sh2 = sh1;
      sm1 = mode; ss1 = sel; sh1 = hold;
    end
`else
    um = mode; us = sel; uh = hold;
`endif
    if (rst) begin
      m_cnt = 0; m_tog = 1'b0; m_idx = '0; m_pe = 1'b0; m_data = '0; m_tick = 1'b0;
    end else if (uh) begin
      m_tick = 1'b0;
    end else begin
      m_data = exp_data(um, us, m_tog, m_idx);
      m_tick = m_pe;
      m_pe   = (m_cnt == P - 1);
      if (m_cnt == P - 1) begin
        m_tog = ~m_tog;
        m_idx = m_idx + 2'd1;
        m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    e.d = m_data;
    e.t = m_tick;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    edge_n = rst ? 0 : edge_n + 1;
    e = sbq.pop_front();
    chk("sb_data", data, e.d);
    chk("sb_tick", {3'b000, tick}, {3'b000, e.t});
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cyc();
    rst = 1'b0;
  endtask

  task automatic run_to(input int k);
    while (edge_n < k) cyc();
  endtask

  initial begin
    logic [3:0] exp_scan;
    rst = 1'b1; mode = 2'b00; sel = 2'd2; hold = 1'b0;

    // Reset state
    do_reset(3);
    chk("rst_data", data, 4'b0000);
    chk("rst_tick", {3'b000, tick}, 4'b0000);

    // SELECT, i_sel=2
    run_to(7);
    chk("sel_e7", data, 4'b0000);
    run_to(8);
    chk("sel_e8", data, 4'b0100);
    chk("sel_tick8", {3'b000, tick}, 4'b0001);
    run_to(14);
    chk("sel_e14", data, 4'b0100);
    chk("sel_tick14", {3'b000, tick}, 4'b0000);
    run_to(15);
    chk("sel_e15", data, 4'b0000);
    chk("sel_tick15", {3'b000, tick}, 4'b0001);

    // SCAN with i_sel changing every cycle
    mode = 2'b01;
    do_reset(2);
    for (int e = 1; e <= 29; e++) begin
      sel = sel + 2'd1;
      cyc();
`ifndef LFSR_DEMUX_SEQUENCER_SYNC_EN
      if (e % 7 == 1) begin
        exp_scan = 4'b0001 << ((e / 7) % 4);
        chk("scan_step", data, exp_scan);
      end
`endif
    end

    // ALL / OFF switching
    mode = 2'b10;
    do_reset(2);
    run_to(8);
    chk("all_e8", data, 4'b1111);
    run_to(10);
    mode = 2'b11;
`ifndef LFSR_DEMUX_SEQUENCER_SYNC_EN
    run_to(11);
    chk("off_e11", data, 4'b0000);
    run_to(12);
    mode = 2'b10;
    run_to(13);
    chk("all_e13", data, 4'b1111);
    run_to(15);
    chk("all_e15", data, 4'b0000);
    chk("all_tick15", {3'b000, tick}, 4'b0001);
`else
    run_to(12);
    chk("sync_e12", data, 4'b1111);
    run_to(13);
    chk("sync_e13", data, 4'b0000);
    mode = 2'b10;
    hold = 1'b1;
    cyc();
    hold = 1'b0;
    run_to(22);
    chk("sync_tick22", {3'b000, tick}, 4'b0000);
    run_to(23);
    chk("sync_tick23", {3'b000, tick}, 4'b0001);
`endif

    // Hold for 5 cycles mid-period
    mode = 2'b10;
    do_reset(2);
    run_to(3);
    hold = 1'b1;
    repeat (5) cyc();
    hold = 1'b0;
    chk("hold_tick8", {3'b000, tick}, 4'b0000);
    run_to(12);
    chk("hold_e12", data, 4'b0000);
    chk("hold_tick12", {3'b000, tick}, 4'b0000);
    run_to(13);
    chk("hold_e13", data, 4'b1111);
    chk("hold_tick13", {3'b000, tick}, 4'b0001);

    // Reset pulse at cycle 10 of a period
    do_reset(2);
    run_to(10);
    chk("mid_e10", data, 4'b1111);
    rst = 1'b1;
    cyc();
    chk("mid_rst_data", data, 4'b0000);
    chk("mid_rst_tick", {3'b000, tick}, 4'b0000);
    rst = 1'b0;
    run_to(7);
    chk("mid_r7", data, 4'b0000);
    run_to(8);
    chk("mid_r8", data, 4'b1111);
    chk("mid_tick8", {3'b000, tick}, 4'b0001);

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      mode = 2'($urandom_range(0, 3));
      sel  = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 7) == 0);
      rst  = ($urandom_range(0, 99) == 0);
      cyc();
    end
    rst = 1'b0;
    hold = 1'b0;
    repeat (20) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
